// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage with a small in-order {pc, instr} buffer
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   iaddr / idata                 instruction memory address out, same-cycle data in
//   fetch_en                      allows new fetches
//   redirect_valid / redirect_pc  branch/jump redirect pulse and target
//   if_valid/if_pc/if_instr       buffer head toward the consumer
//   if_ready                      consumer accepts the head this cycle
//   fault / fault_pc              fetch fault flag and offending address
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        fault,
  output logic [31:0] fault_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, fault_pc_nx;
  logic fault_nx;
  logic [31:0] buf_pc [DEPTH];
  logic [31:0] buf_instr [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic active, in_range, pop, push, flush;
  assign iaddr    = pc;
  assign if_valid = count != '0;
  assign if_pc    = if_valid ? buf_pc[rd_ptr] : '0;
  assign if_instr = if_valid ? buf_instr[rd_ptr] : '0;
  assign active   = state == FETCH && fetch_en && !redirect_valid;
  assign in_range = {2'b00, pc[31:2]} < 32'(IMEM_WORDS);
  assign pop      = if_valid && if_ready;
  assign push     = active && in_range && (count < CW'(DEPTH) || pop);
  // a redirect discards everything, including an entry popped in the same cycle
  assign flush    = redirect_valid && state != IDLE;
  always_comb begin
    state_nx    = state;
    pc_nx       = push ? pc + 32'd4 : pc;
    fault_nx    = fault;
    fault_pc_nx = fault_pc;
    if (state == IDLE) begin
      state_nx = FETCH;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        state_nx = FETCH;
        pc_nx    = redirect_pc;
        fault_nx = 1'b0;
      end else begin
        state_nx    = FAULT;
        fault_nx    = 1'b1;
        fault_pc_nx = redirect_pc;
      end
    end else if (active && !in_range) begin
      state_nx    = FAULT;
      fault_nx    = 1'b1;
      fault_pc_nx = pc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      fault    <= fault_nx;
      fault_pc <= fault_pc_nx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // payload needs no reset: head outputs are masked while the buffer is empty
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= pc;
      buf_instr[wr_ptr] <= idata;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scoreboard bench for ifetch_unit
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst_n, fetch_en, redirect_valid, if_ready;
  logic [31:0] redirect_pc, iaddr, idata, if_pc, if_instr, fault_pc;
  logic if_valid, fault;
  logic [31:0] mem [32];
  logic [63:0] q [$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign idata = (iaddr[31:7] == '0) ? mem[iaddr[6:2]] : 32'hDEAD_BEEF;
  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .iaddr(iaddr), .idata(idata), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready), .fault(fault), .fault_pc(fault_pc)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, want);
    end
  endtask
  task automatic exp(input logic [31:0] p);
    q.push_back({p, mem[p[6:2]]});
  endtask
  task automatic cyc();
    @(negedge clk);
    if (if_valid && if_ready) begin
      if (q.size() == 0) chk("extra_delivery", {if_pc, if_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("delivery", {if_pc, if_instr}, q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = {i[11:0], 20'h00013};
    mem[0] = 32'h0000_0513;
    mem[1] = 32'h0010_0593;
    mem[2] = 32'h0020_0613;
    mem[8] = 32'h02F6_F463;
    mem[9] = 32'hB580_0093;
    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_pc_instr", {if_pc, if_instr}, 64'h0);
    chk("rst_fault", {fault, fault_pc}, 33'h0);
    // startup stream
    fetch_en = 1'b1; if_ready = 1'b1; rst_n = 1'b1;
    exp(32'h0); exp(32'h4); exp(32'h8);
    @(posedge clk); #1;
    chk("bubble", if_valid, 1'b0);
    cyc();
    chk("first_valid", {if_valid, if_pc}, {1'b1, 32'h0});
    cyc(); cyc();
    fetch_en = 1'b0;
    cyc(); cyc();
    chk("drain_a", 64'(q.size()), 64'd0);
    // backpressure
    redirect_valid = 1'b1; redirect_pc = 32'h0; if_ready = 1'b0; fetch_en = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("hold_iaddr", iaddr, 32'h8);
    chk("hold_head", {if_valid, if_pc}, {1'b1, 32'h0});
    exp(32'h0); exp(32'h4); exp(32'h8);
    if_ready = 1'b1;
    cyc();
    fetch_en = 1'b0;
    cyc(); cyc(); cyc();
    chk("drain_b", 64'(q.size()), 64'd0);
    // redirect flushes buffered entries
    if_ready = 1'b0; fetch_en = 1'b1;
    cyc(); cyc(); cyc();
    chk("full_head", {if_valid, if_pc}, {1'b1, 32'hC});
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    cyc();
    chk("flushed", if_valid, 1'b0);
    redirect_valid = 1'b0; if_ready = 1'b1;
    exp(32'h20);
    cyc();
    fetch_en = 1'b0;
    cyc(); cyc();
    chk("drain_c", 64'(q.size()), 64'd0);
    // misaligned redirect then recovery
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h22;
    cyc();
    redirect_valid = 1'b0;
    chk("mis_fault", {fault, fault_pc}, {1'b1, 32'h22});
    chk("mis_valid", if_valid, 1'b0);
    cyc(); cyc();
    chk("fault_stays", {fault, if_valid}, 2'b10);
    redirect_valid = 1'b1; redirect_pc = 32'h24;
    cyc();
    redirect_valid = 1'b0;
    chk("fault_clear", fault, 1'b0);
    exp(32'h24);
    cyc();
    fetch_en = 1'b0;
    cyc(); cyc();
    chk("drain_d", 64'(q.size()), 64'd0);
    // end of memory
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h78;
    exp(32'h78); exp(32'h7C);
    cyc();
    redirect_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("range_fault", {fault, fault_pc}, {1'b1, 32'h80});
    chk("range_iaddr", iaddr, 32'h80);
    chk("drain_e", 64'(q.size()), 64'd0);
    // asynchronous reset mid-cycle
    redirect_valid = 1'b1; redirect_pc = 32'h0; if_ready = 1'b0;
    cyc();
    redirect_valid = 1'b0;
    cyc(); cyc();
    chk("pre_rst_valid", {if_valid, if_pc}, {1'b1, 32'h0});
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", if_valid, 1'b0);
    chk("async_head", {if_pc, if_instr}, 64'h0);
    chk("async_iaddr", iaddr, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1; if_ready = 1'b1; fetch_en = 1'b1;
    exp(32'h0); exp(32'h4);
    @(posedge clk); #1;
    chk("re_bubble", if_valid, 1'b0);
    cyc(); cyc();
    fetch_en = 1'b0;
    cyc(); cyc();
    chk("drain_f", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
